// File: rtl/trip_multi_pkg.sv
// Shared widths and helpers for the multi-channel energy-trip detector.
package trip_multi_pkg;

   localparam int unsigned DEF_DW    = 9;
   localparam int unsigned DEF_SW    = 12;
   localparam int unsigned DEF_AW    = 24;
   localparam int unsigned DEF_SHIFT = 5;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
      end
      return r;
   endfunction

   // Right-shift the window sum and clip it to an sw-bit unsigned value.
   function automatic logic [31:0] sat_energy(input logic [63:0] sum,
                                              input int unsigned shift,
                                              input int unsigned sw);
      logic [63:0] s;
      logic [63:0] lim;
      s   = sum >> shift;
      lim = (64'd1 << sw) - 64'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/trip_multi_if.sv
// Sample stream, control and result bundle of trip_multi.
interface trip_multi_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = trip_multi_pkg::DEF_DW,
   parameter int unsigned SW  = trip_multi_pkg::DEF_SW
);
   import trip_multi_pkg::*;

   localparam int unsigned CW = (clog2(NCH) > 0) ? clog2(NCH) : 1;

   logic [NCH*DW-1:0] inval;
   logic              in_valid;
   logic              in_last;
   logic [SW-1:0]     trip_thresh;
   logic [NCH-1:0]    trip_mask;
   logic              trip_clear;
   logic              peak_clear;
   logic [NCH-1:0]    tripped;
   logic              trip_any;
   logic [CW-1:0]     first_ch;
   logic [NCH*SW-1:0] peak_val;
   logic              win_done;

   modport master (
      output inval, in_valid, in_last, trip_thresh, trip_mask, trip_clear, peak_clear,
      input  tripped, trip_any, first_ch, peak_val, win_done
   );

   modport slave (
      input  inval, in_valid, in_last, trip_thresh, trip_mask, trip_clear, peak_clear,
      output tripped, trip_any, first_ch, peak_val, win_done
   );

endinterface

// File: rtl/trip_multi_chan.sv
// One channel: square, window accumulate, scale/saturate, threshold compare,
// consecutive-window counter, trip latch and peak tracking.
module trip_chan #(
   parameter int unsigned DW      = trip_multi_pkg::DEF_DW,
   parameter int unsigned SW      = trip_multi_pkg::DEF_SW,
   parameter int unsigned SHIFT   = trip_multi_pkg::DEF_SHIFT,
   parameter int unsigned AW      = trip_multi_pkg::DEF_AW,
   parameter int unsigned NCONSEC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [DW-1:0] sample,
   input  logic                 s1_valid,
   input  logic                 s1_last,
   input  logic                 s2_done,
   input  logic [SW-1:0]        thresh,
   input  logic                 mask,
   input  logic                 trip_clear,
   input  logic                 peak_clear,
   output logic                 tripped,
   output logic                 tripped_nxt_c,
   output logic [SW-1:0]        peak
);
   import trip_multi_pkg::*;

   localparam int unsigned PW = 2 * DW;
   localparam int unsigned QW = 2 * DW - 1;

   logic signed [PW-1:0] sq_full_c;
   logic [QW-1:0]        sq;
   logic [AW-1:0]        acc;
   logic [AW-1:0]        sum2;
   logic [AW-1:0]        acc_sum_c;
   logic [SW-1:0]        e_c;
   logic                 over_c;
   logic [3:0]           cnt;
   logic [3:0]           cnt_base_c;
   logic [3:0]           cnt_nxt_c;

   assign sq_full_c = PW'(sample) * PW'(sample);
   assign acc_sum_c = acc + AW'(sq);
   assign e_c       = SW'(sat_energy(64'(sum2), SHIFT, SW));
   assign over_c    = e_c > thresh;

   // A coincident trip_clear wipes state before the window is scored.
   always_comb begin
      cnt_base_c    = trip_clear ? 4'd0 : cnt;
      tripped_nxt_c = trip_clear ? 1'b0 : tripped;
      cnt_nxt_c     = cnt_base_c;
      if (s2_done) begin
         if (over_c && mask)
            cnt_nxt_c = (cnt_base_c >= 4'(NCONSEC)) ? 4'(NCONSEC) : cnt_base_c + 4'd1;
         else
            cnt_nxt_c = 4'd0;
         if (cnt_nxt_c == 4'(NCONSEC)) tripped_nxt_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq      <= '0;
         acc     <= '0;
         sum2    <= '0;
         cnt     <= '0;
         tripped <= 1'b0;
         peak    <= '0;
      end else begin
         sq      <= sq_full_c[QW-1:0];
         cnt     <= cnt_nxt_c;
         tripped <= tripped_nxt_c;
         if (s1_valid) begin
            if (s1_last) begin
               sum2 <= acc_sum_c;
               acc  <= '0;
            end else begin
               acc  <= acc_sum_c;
            end
         end
         if (s2_done)
            peak <= (peak_clear || (e_c > peak)) ? e_c : peak;
         else if (peak_clear)
            peak <= '0;
      end
   end

endmodule

// File: rtl/trip_multi.sv
// Multi-channel energy-trip detector: flag pipeline, per-channel datapaths,
// trip_any and first-faulting-channel capture.
module trip_multi #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned DW      = trip_multi_pkg::DEF_DW,
   parameter int unsigned SW      = trip_multi_pkg::DEF_SW,
   parameter int unsigned SHIFT   = trip_multi_pkg::DEF_SHIFT,
   parameter int unsigned AW      = trip_multi_pkg::DEF_AW,
   parameter int unsigned NCONSEC = 1
) (
   input logic        clk,
   input logic        rst_n,
   trip_multi_if.slave bus
);
   import trip_multi_pkg::*;

   localparam int unsigned CW = (clog2(NCH) > 0) ? clog2(NCH) : 1;

   logic                   s1_valid;
   logic                   s1_last;
   logic                   s2_done;
   logic                   win_done_q;
   logic                   trip_any_q;
   logic [CW-1:0]          first_q;
   logic [NCH-1:0]         tripped_q;
   logic [NCH-1:0]         trip_nxt_c;
   logic [NCH-1:0][SW-1:0] peak_q;
   logic [CW-1:0]          low_c;
   logic                   any_base_c;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      trip_chan #(
         .DW(DW), .SW(SW), .SHIFT(SHIFT), .AW(AW), .NCONSEC(NCONSEC)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .sample       (bus.inval[k*DW +: DW]),
         .s1_valid     (s1_valid),
         .s1_last      (s1_last),
         .s2_done      (s2_done),
         .thresh       (bus.trip_thresh),
         .mask         (bus.trip_mask[k]),
         .trip_clear   (bus.trip_clear),
         .peak_clear   (bus.peak_clear),
         .tripped      (tripped_q[k]),
         .tripped_nxt_c(trip_nxt_c[k]),
         .peak         (peak_q[k])
      );
   end

   // Lowest-index channel among the next trip flags.
   always_comb begin
      low_c      = '0;
      any_base_c = bus.trip_clear ? 1'b0 : trip_any_q;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         if (trip_nxt_c[k]) low_c = CW'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s2_done    <= 1'b0;
         win_done_q <= 1'b0;
         trip_any_q <= 1'b0;
         first_q    <= '0;
      end else begin
         s1_valid   <= bus.in_valid;
         s1_last    <= bus.in_valid & bus.in_last;
         s2_done    <= s1_valid & s1_last;
         win_done_q <= s2_done;
         trip_any_q <= |trip_nxt_c;
         if (!any_base_c && (|trip_nxt_c))
            first_q <= low_c;
         else if (bus.trip_clear)
            first_q <= '0;
      end
   end

   assign bus.tripped  = tripped_q;
   assign bus.trip_any = trip_any_q;
   assign bus.first_ch = first_q;
   assign bus.peak_val = peak_q;
   assign bus.win_done = win_done_q;

endmodule

// File: doc/trip_multi.md
Name: trip_multi

Overview:
- Multi-channel, parametrised energy-trip detector for gated sample windows (e.g. RF pulse interlock).
- Per channel: accumulates squares of signed samples over a window, scales and saturates the sum, and compares it against a runtime threshold.
- Channel trips after NCONSEC consecutive over-threshold windows. Also tracks a per-channel peak and captures the first channel to fault.
- Sits between ADC/decimator sample streams and the interlock/readout register bank.

Parameters:
NCH, 4, number of channels
DW, 9, signed sample width per channel
SW, 12, unsigned width of scaled energy, threshold and peak
SHIFT, 5, right shift applied to the accumulated sum before saturation to SW bits
AW, 24, accumulator width; must satisfy AW >= 2*DW+log2(max samples per window)
NCONSEC, 1, consecutive over-threshold windows required to trip (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inval  in  NCH*DW  packed signed samples; channel k at bits [k*DW +: DW]
in_valid  in  1  samples valid this cycle; accumulate
in_last  in  1  with in_valid: last sample of window
trip_thresh  in  SW  unsigned threshold, shared by all channels
trip_mask  in  NCH  1 = channel enabled for tripping
trip_clear  in  1  synchronous clear of trip state and consecutive counters
peak_clear  in  1  synchronous clear of peak values
tripped  out  NCH  latched per-channel trip flags
trip_any  out  1  OR of tripped
first_ch  out  clog2(NCH) (min 1)  index of first channel tripped since last clear
peak_val  out  NCH*SW  packed per-channel peak scaled energy
win_done  out  1  one-cycle strobe when a window result is evaluated

Behaviour:
- Reset (rst_n low, async): all pipeline registers, accumulators, counters, tripped, trip_any, first_ch, peak_val and win_done go to 0.
- Stage 1 (cycle t+1): register each sample's square as unsigned 2*DW-1 bits, plus the in_valid and in_last flags.
- Stage 2 (cycle t+2):
  - Accumulator adds the square when the stage-1 valid flag is set.
  - When the stage-1 last flag is set, the final sum is presented and the accumulator restarts from 0 on the next valid sample.
  - Gaps (in_valid low) inside a window are allowed.
  - in_last without in_valid is ignored.
- Stage 3 (cycle t+3):
  - Scaled energy e = min(sum >> SHIFT, 2^SW-1).
  - win_done pulses.
  - Comparison is strict: over = e > trip_thresh.
- Latency: for a last sample at cycle t, win_done, peak_val, tripped, trip_any and first_ch reflect that window at cycle t+3.
- Consecutive counter, per channel:
  - over && trip_mask[k]: increment, saturating at NCONSEC.
  - Otherwise: reset to 0.
  - When the count reaches NCONSEC, tripped[k] sets and stays set until trip_clear.
- Masked channels never trip; their counters are held at 0.
- first_ch:
  - Loads when trip_any goes 0->1.
  - If several channels trip in the same cycle, the lowest index wins.
  - Holds its value while trip_any stays high.
  - Cleared to 0 by trip_clear.
- Peak: at win_done, peak_val[k] = max(peak_val[k], e_k), regardless of mask.
- trip_clear in the same cycle as win_done:
  - Counters and tripped clear first.
  - The window is then evaluated from count 0, so with NCONSEC=1 an over window re-trips (set wins).
- peak_clear in the same cycle as win_done: peak loads that window's e_k.
- trip_thresh and trip_mask are sampled at stage 3 only.
- Reset mid-window: the partial sum is discarded.

Decomposition:
- Shared package holds:
  - clog2 function
  - default widths DW, SW, AW
  - energy saturation helper (shift+clip)
- One natural sub-module, trip_chan:
  - Holds one channel's square, accumulator, scaling, compare, consecutive counter and peak.
  - Instantiated NCH times by generate.
- Top level owns the flag pipeline, trip_any, first_ch priority logic and win_done.

Test Plan:
- Defaults, ch0 window {100,-100} -> 20000>>5 = 625 > 600 -> tripped = 4'b0001, first_ch = 0, peak_val[0] = 625, all exactly 3 cycles after in_last.
- ch1 window {50,50} -> e = 156, tripped[1] stays 0, peak_val[1] = 156. Next ch1 window {-256,-256} -> e = 4095 (saturated), peak_val[1] = 4095.
- NCONSEC=3 build, ch2 over-threshold windows: over, over, under, over, over, over -> tripped[2] asserts only after the sixth window.
- ch0 and ch3 both first exceed in the same window -> first_ch = 0. A later ch1 trip leaves first_ch = 0.
- trip_mask = 4'b1110 with ch0 e = 625 -> tripped[0] = 0, peak_val[0] = 625. trip_clear coincident with ch3 over window (NCONSEC=1) -> tripped[3] = 1 afterwards.
- rst_n pulsed low mid-window -> all outputs 0 immediately (async). Next full window {10,10} -> peak_val = 6.
